// File: rtl/viterbi_pkg.sv
// Shared trellis constants and the rate-1/2 convolutional encoder used by the
// branch-metric scheduler and any trellis model.
package viterbi_pkg;

    localparam int K          = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;
    localparam int NUM_STATES = 1 << (K - 1);
    localparam int NB         = 2 * NUM_STATES;

    // Widest constraint length the encoder helper supports.
    localparam int KMAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    // Encoder register is {b, state} with the newest bit in the MSB; returns {e1, e0}.
    // Bits of state above k-2 must be zero.
    function automatic logic [1:0] conv_encode(
        input logic [KMAX-2:0] state,
        input logic            b,
        input int              k  = K,
        input logic [KMAX-1:0] g0 = KMAX'(G0),
        input logic [KMAX-1:0] g1 = KMAX'(G1)
    );
        logic [KMAX-1:0] r;
        r = {1'b0, state} | (KMAX'(b) << (k - 1));
        return {^(r & g0), ^(r & g1)};
    endfunction

endpackage

// File: rtl/branch_metric_calc.sv
// Hamming distance between a received rate-1/2 symbol and an expected codeword.
module branch_metric_calc (
    input  logic [1:0] sym_q_i,
    input  logic [1:0] code_i,
    output logic [1:0] metric_o
);

    logic [1:0] diff;

    assign diff     = sym_q_i ^ code_i;
    assign metric_o = {1'b0, diff[1]} + {1'b0, diff[0]};

endmodule

// File: rtl/viterbi_bm_sched.sv
// Branch-metric scheduler: walks every trellis branch of one received symbol
// through a single shared XOR/popcount datapath, one metric per transfer.
module viterbi_bm_sched
    import viterbi_pkg::*;
#(
    parameter int           K  = viterbi_pkg::K,
    parameter logic [K-1:0] G0 = K'(viterbi_pkg::G0),
    parameter logic [K-1:0] G1 = K'(viterbi_pkg::G1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         sym_valid,
    output logic         sym_ready,
    input  logic [1:0]   sym,
    output logic         bm_valid,
    input  logic         bm_ready,
    output logic [K-2:0] bm_state,
    output logic         bm_bit,
    output logic [1:0]   bm_metric,
    output logic         bm_last,
    output logic         busy
);

    fsm_state_e      state_q, state_d;
    logic [K-1:0]    idx_q, idx_d;
    logic [1:0]      sym_q, sym_d;
    logic [KMAX-2:0] src_state;
    logic [1:0]      code;
    logic [1:0]      metric;
    logic            at_last;
    logic            accept;
    logic            xfer;

    assign at_last = (idx_q == '1);
    assign accept  = (state_q == IDLE) && sym_valid && !clear;
    assign xfer    = (state_q == RUN) && bm_ready && !clear;

    // Branch order is state-major: idx = {source state, hypothesised bit}.
    assign src_state = (KMAX-1)'(idx_q[K-1:1]);
    assign code      = conv_encode(src_state, idx_q[0], K, KMAX'(G0), KMAX'(G1));

    branch_metric_calc u_bmc (
        .sym_q_i  (sym_q),
        .code_i   (code),
        .metric_o (metric)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (sym_valid) state_d = RUN;
                RUN:     if (bm_ready && at_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // clear outranks both acceptance and transfer on the same edge.
    always_comb begin
        idx_d = idx_q;
        sym_d = sym_q;
        if (clear) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = '0;
            sym_d = sym;
        end else if (xfer) begin
            idx_d = idx_q + K'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            sym_q <= '0;
        end else begin
            idx_q <= idx_d;
            sym_q <= sym_d;
        end
    end

    // Outputs decode from registered state only; branch fields are zero unless valid.
    always_comb begin
        sym_ready = 1'b0;
        bm_valid  = 1'b0;
        busy      = 1'b0;
        bm_state  = '0;
        bm_bit    = 1'b0;
        bm_metric = 2'd0;
        bm_last   = 1'b0;
        case (state_q)
            IDLE: sym_ready = 1'b1;
            RUN: begin
                bm_valid  = 1'b1;
                busy      = 1'b1;
                bm_state  = idx_q[K-1:1];
                bm_bit    = idx_q[0];
                bm_metric = metric;
                bm_last   = at_last;
            end
            default: sym_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_viterbi_bm_sched.sv
// Scoreboard bench for viterbi_bm_sched with default K=3, G0=111, G1=101.
module tb_viterbi_bm_sched;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym;
    logic       bm_valid;
    logic       bm_ready;
    logic [1:0] bm_state;
    logic       bm_bit;
    logic [1:0] bm_metric;
    logic       bm_last;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] tag;
        logic [1:0] st;
        logic       b;
        logic [1:0] m;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [7:0] id;
        logic       ready;
        logic       valid;
        logic       busy;
        logic       drain;
    } ctl_t;

    beat_t beat_q[$];
    ctl_t  ctl_q[$];

    // Hand-computed metrics per received symbol {r1,r0}, in idx order.
    // Codewords for idx 0..7: 00 11 11 00 10 01 01 10.
    int m_tab [4][8] = '{'{0, 2, 2, 0, 1, 1, 1, 1},
                         '{1, 1, 1, 1, 2, 0, 0, 2},
                         '{1, 1, 1, 1, 0, 2, 2, 0},
                         '{2, 0, 0, 2, 1, 1, 1, 1}};

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    viterbi_bm_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym       (sym),
        .bm_valid  (bm_valid),
        .bm_ready  (bm_ready),
        .bm_state  (bm_state),
        .bm_bit    (bm_bit),
        .bm_metric (bm_metric),
        .bm_last   (bm_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s tag=%0d actual=%0d required=%0d", nm, tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [1:0] s, input logic [7:0] t);
        beat_t e;
        for (int i = 0; i < 8; i++) begin
            e.tag  = t;
            e.st   = 2'(i >> 1);
            e.b    = 1'(i & 1);
            e.m    = 2'(m_tab[s][i]);
            e.last = (i == 7);
            beat_q.push_back(e);
        end
    endtask

    task automatic push_ctl(input logic [7:0] id, input logic r, input logic v,
                            input logic b, input logic d = 1'b0);
        ctl_t c;
        c.id    = id;
        c.ready = r;
        c.valid = v;
        c.busy  = b;
        c.drain = d;
        ctl_q.push_back(c);
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] t);
        sym       = s;
        sym_valid = 1'b1;
        push_beats(s, t);
        push_ctl(t, 1'b1, 1'b0, 1'b0);
        step();
        sym_valid = 1'b0;
        sym       = ~s;
        push_ctl(8'(t + 1), 1'b0, 1'b1, 1'b1);
        repeat (8) step();
        push_ctl(8'(t + 2), 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: control expectations, idle zero-forcing and scoreboard beats.
    always @(negedge clk) begin
        ctl_t  c;
        beat_t e;
        while (ctl_q.size() != 0) begin
            c = ctl_q.pop_front();
            chk("sym_ready", int'(c.id), int'(sym_ready), int'(c.ready));
            chk("bm_valid", int'(c.id), int'(bm_valid), int'(c.valid));
            chk("busy", int'(c.id), int'(busy), int'(c.busy));
            if (c.drain) chk("beats_left", int'(c.id), beat_q.size(), 0);
        end
        if (!bm_valid) begin
            chk("idle_zero", 0, int'({bm_state, bm_bit, bm_metric, bm_last}), 0);
        end else if (rst_n) begin
            chk("beat_expected", 0, int'(beat_q.size() > 0), 1);
            if (beat_q.size() > 0) begin
                e = bm_ready ? beat_q.pop_front() : beat_q[0];
                chk("bm_state", int'(e.tag), int'(bm_state), int'(e.st));
                chk("bm_bit", int'(e.tag), int'(bm_bit), int'(e.b));
                chk("bm_metric", int'(e.tag), int'(bm_metric), int'(e.m));
                chk("bm_last", int'(e.tag), int'(bm_last), int'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        sym_valid = 1'b0;
        sym       = 2'b00;
        bm_ready  = 1'b1;
        step();
        step();
        push_ctl(8'd1, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        push_ctl(8'd2, 1'b1, 1'b0, 1'b0);
        step();

        // All-zeros and all-ones symbols at full rate
        send(2'b00, 8'd10);
        send(2'b11, 8'd20);

        // Backpressure with ready pattern 1,0,0,1
        sym       = 2'b10;
        sym_valid = 1'b1;
        push_beats(2'b10, 8'd30);
        step();
        sym_valid = 1'b0;
        sym       = 2'b01;
        for (int c = 0; c < 16; c++) begin
            bm_ready = pat[c % 4];
            step();
        end
        bm_ready = 1'b1;
        push_ctl(8'd31, 1'b1, 1'b0, 1'b0);
        step();

        // Clear on the 4th beat with ready high
        sym       = 2'b00;
        sym_valid = 1'b1;
        push_beats(2'b00, 8'd40);
        step();
        sym_valid = 1'b0;
        repeat (3) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        beat_q.delete();
        push_ctl(8'd41, 1'b1, 1'b0, 1'b0);
        step();

        // Clear while idle blocks acceptance
        clear     = 1'b1;
        sym_valid = 1'b1;
        sym       = 2'b11;
        step();
        clear     = 1'b0;
        sym_valid = 1'b0;
        push_ctl(8'd42, 1'b1, 1'b0, 1'b0);
        step();
        send(2'b11, 8'd50);

        // Back-to-back with sym_valid held high
        sym       = 2'b00;
        sym_valid = 1'b1;
        push_beats(2'b00, 8'd60);
        push_ctl(8'd60, 1'b1, 1'b0, 1'b0);
        step();
        sym = 2'b11;
        for (int i = 0; i < 8; i++) begin
            push_ctl(8'd61, 1'b0, 1'b1, 1'b1);
            step();
        end
        push_ctl(8'd62, 1'b1, 1'b0, 1'b0);
        push_beats(2'b11, 8'd63);
        step();
        sym_valid = 1'b0;
        sym       = 2'b01;
        for (int i = 0; i < 8; i++) begin
            push_ctl(8'd64, 1'b0, 1'b1, 1'b1);
            step();
        end
        push_ctl(8'd65, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN
        sym       = 2'b11;
        sym_valid = 1'b1;
        push_beats(2'b11, 8'd70);
        step();
        sym_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        beat_q.delete();
        push_ctl(8'd71, 1'b1, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        push_ctl(8'd72, 1'b1, 1'b0, 1'b0);
        step();
        send(2'b10, 8'd80);

        push_ctl(8'd90, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
